// File: rtl/caesar_entry_display_if.sv
// caesar_entry_display_if: key-entry / cipher-control / display bus of caesar_entry_display.
//   master (driver side): sym_in_i, ready_i, start_i, clear_i, shift_key_i, decrypt_i out;
//                         saida_o, char_valid_o, count_o, busy_o, done_o, err_o in
//   slave  (design side): the same signals with directions reversed
interface caesar_entry_display_if #(
    parameter int NUM_CHARS = 4,
    parameter int SYM_W     = 5
);
    localparam int CW = $clog2(NUM_CHARS + 1);
    logic [SYM_W-1:0]           sym_in_i;
    logic                       ready_i;
    logic                       start_i;
    logic                       clear_i;
    logic [SYM_W-1:0]           shift_key_i;
    logic                       decrypt_i;
    logic [NUM_CHARS*SYM_W-1:0] saida_o;
    logic [NUM_CHARS-1:0]       char_valid_o;
    logic [CW-1:0]              count_o;
    logic                       busy_o;
    logic                       done_o;
    logic                       err_o;
    modport master (
        output sym_in_i, ready_i, start_i, clear_i, shift_key_i, decrypt_i,
        input  saida_o, char_valid_o, count_o, busy_o, done_o, err_o
    );
    modport slave (
        input  sym_in_i, ready_i, start_i, clear_i, shift_key_i, decrypt_i,
        output saida_o, char_valid_o, count_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/caesar_entry_display.sv
// caesar_entry_display: letter-entry buffer with in-place Caesar cipher and registered per-slot display codes.
//   clk            rising-edge clock
//   reset          synchronous active-high reset, highest priority
//   bus.sym_in_i   symbol to capture        bus.ready_i    capture request (edge acts)
//   bus.start_i    cipher request (edge)    bus.clear_i    empty the buffer (level)
//   bus.shift_key_i shift amount            bus.decrypt_i  0 = +key, 1 = -key
//   bus.saida_o    slot i at [i*SYM_W +: SYM_W], BLANK_CODE when empty
//   bus.char_valid_o slot occupancy         bus.count_o    symbols held
//   bus.busy_o     high while ciphering     bus.done_o     pulse after last slot ciphered
//   bus.err_o      pulse on rejected capture
module caesar_entry_display #(
    parameter int NUM_CHARS  = 4,
    parameter int SYM_W      = 5,
    parameter int ALPHA      = 26,
    parameter int BLANK_CODE = 31
) (
    input logic clk,
    input logic reset,
    caesar_entry_display_if.slave bus
);
    localparam int CW = $clog2(NUM_CHARS + 1);
    localparam int IW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [SYM_W:0]   ALPHA_W = (SYM_W + 1)'(ALPHA);
    localparam logic [SYM_W-1:0] BLANK   = SYM_W'(BLANK_CODE);

    typedef enum logic [1:0] {ENTRY, CIPHER, SHOW} state_t;

    state_t                     state_q, state_d;
    logic [SYM_W-1:0]           buf_q [NUM_CHARS];
    logic [SYM_W-1:0]           buf_d [NUM_CHARS];
    logic [NUM_CHARS-1:0]       valid_q, valid_d;
    logic [CW-1:0]              count_q, count_d;
    logic [CW-1:0]              idx_q, idx_d;
    logic [SYM_W-1:0]           k_q, k_d;
    logic                       dec_q, dec_d;
    logic                       ready_q, start_q;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [NUM_CHARS*SYM_W-1:0] saida_q, saida_d;
    logic                       ready_e, start_e;
    logic [SYM_W:0]             c_x, k_x, key_x;

    assign ready_e = bus.ready_i & ~ready_q;
    assign start_e = bus.start_i & ~start_q;
    assign c_x     = {1'b0, buf_q[idx_q[IW-1:0]]};
    assign k_x     = {1'b0, k_q};
    assign key_x   = {1'b0, bus.shift_key_i};

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        valid_d = valid_q;
        count_d = count_q;
        idx_d   = idx_q;
        k_d     = k_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        saida_d = '0;
        if (bus.clear_i) begin
            state_d = ENTRY;
            for (int i = 0; i < NUM_CHARS; i++) buf_d[i] = '0;
            valid_d = '0;
            count_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ENTRY, SHOW: begin
                    // Start wins over ready; a ready edge in the same cycle is simply lost.
                    if (start_e && count_q != '0) begin
                        k_d     = SYM_W'((key_x >= ALPHA_W) ? key_x - ALPHA_W : key_x);
                        dec_d   = bus.decrypt_i;
                        idx_d   = '0;
                        state_d = CIPHER;
                    end else if (ready_e) begin
                        if (state_q == ENTRY && {1'b0, bus.sym_in_i} < ALPHA_W
                            && count_q < CW'(NUM_CHARS)) begin
                            buf_d[count_q[IW-1:0]]   = bus.sym_in_i;
                            valid_d[count_q[IW-1:0]] = 1'b1;
                            count_d                  = count_q + CW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CIPHER: begin
                    // Both branches stay below 2*ALPHA, so SYM_W+1 bits never overflow.
                    buf_d[idx_q[IW-1:0]] = dec_q
                        ? SYM_W'((c_x >= k_x) ? c_x - k_x : c_x + ALPHA_W - k_x)
                        : SYM_W'((c_x + k_x >= ALPHA_W) ? c_x + k_x - ALPHA_W : c_x + k_x);
                    idx_d = idx_q + CW'(1);
                    if (idx_q == count_q - CW'(1)) begin
                        state_d = SHOW;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ENTRY;
            endcase
        end
        // Display is built from next-state data so a capture shows one cycle after its edge.
        for (int i = 0; i < NUM_CHARS; i++)
            saida_d[i*SYM_W +: SYM_W] = valid_d[i] ? buf_d[i] : BLANK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENTRY;
            for (int i = 0; i < NUM_CHARS; i++) buf_q[i] <= '0;
            valid_q <= '0;
            count_q <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            dec_q   <= 1'b0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            saida_q <= {NUM_CHARS{BLANK}};
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            dec_q   <= dec_d;
            ready_q <= bus.ready_i;
            start_q <= bus.start_i;
            done_q  <= done_d;
            err_q   <= err_d;
            saida_q <= saida_d;
        end
    end

    assign bus.saida_o      = saida_q;
    assign bus.char_valid_o = valid_q;
    assign bus.count_o      = count_q;
    assign bus.busy_o       = (state_q == CIPHER);
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_caesar_entry_display.sv
// tb_caesar_entry_display: directed-vector self-checking bench for caesar_entry_display.
module tb_caesar_entry_display;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    logic done_seen;

    always #5 clk = ~clk;

    caesar_entry_display_if #(.NUM_CHARS(4), .SYM_W(5)) bus ();

    caesar_entry_display #(.NUM_CHARS(4), .SYM_W(5), .ALPHA(26), .BLANK_CODE(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
        logic [4:0] a5, b5, c5, d5;
        a5 = a[4:0];
        b5 = b[4:0];
        c5 = c[4:0];
        d5 = d[4:0];
        return {d5, c5, b5, a5};
    endfunction

    task automatic capture(input int s);
        bus.sym_in_i = s[4:0];
        bus.ready_i  = 1'b1;
        tick();
        bus.ready_i  = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        tick();
    endtask

    task automatic cipher(input string tag, input int key, input logic dec, input int cycles);
        int n;
        bus.shift_key_i = key[4:0];
        bus.decrypt_i   = dec;
        bus.start_i     = 1'b1;
        tick();
        bus.start_i     = 1'b0;
        n = 0;
        while (bus.busy_o && n < 20) begin
            n++;
            tick();
        end
        chk({tag, " busy cycles"}, n, cycles);
        chk({tag, " done pulse"}, bus.done_o, 1);
        tick();
        chk({tag, " done drop"}, bus.done_o, 0);
    endtask

    initial begin
        bus.sym_in_i    = '0;
        bus.ready_i     = 1'b0;
        bus.start_i     = 1'b0;
        bus.clear_i     = 1'b0;
        bus.shift_key_i = '0;
        bus.decrypt_i   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset saida", bus.saida_o, 20'hFFFFF);
        chk("reset count", bus.count_o, 0);
        chk("reset valid", bus.char_valid_o, 0);
        chk("reset busy", bus.busy_o, 0);
        chk("reset done/err", {bus.done_o, bus.err_o}, 0);

        bus.sym_in_i = 5'd7;
        bus.ready_i  = 1'b1;
        tick();
        chk("first capture visible", bus.saida_o, pk(7, 31, 31, 31));
        bus.ready_i  = 1'b0;
        tick();
        capture(4);
        capture(11);
        capture(11);
        chk("entry count", bus.count_o, 4);
        chk("entry valid", bus.char_valid_o, 4'b1111);
        chk("entry saida", bus.saida_o, pk(7, 4, 11, 11));

        cipher("enc k3", 3, 1'b0, 4);
        chk("enc k3 saida", bus.saida_o, pk(10, 7, 14, 14));
        cipher("dec k29", 29, 1'b1, 4);
        chk("dec k29 saida", bus.saida_o, pk(7, 4, 11, 11));

        bus.sym_in_i = 5'd2;
        bus.ready_i  = 1'b1;
        tick();
        chk("show ready err", bus.err_o, 1);
        bus.ready_i  = 1'b0;
        tick();
        chk("show ready err drop", bus.err_o, 0);
        chk("show ready no store", bus.saida_o, pk(7, 4, 11, 11));

        do_clear();
        chk("clear saida", bus.saida_o, 20'hFFFFF);
        chk("clear count", bus.count_o, 0);
        capture(25);
        capture(0);
        chk("wrap entry valid", bus.char_valid_o, 4'b0011);
        cipher("wrap enc", 1, 1'b0, 2);
        chk("wrap enc saida", bus.saida_o, pk(0, 1, 31, 31));
        cipher("wrap dec", 1, 1'b1, 2);
        chk("wrap dec saida", bus.saida_o, pk(25, 0, 31, 31));
        cipher("wrap dec2", 1, 1'b1, 2);
        chk("wrap dec2 saida", bus.saida_o, pk(24, 25, 31, 31));

        do_clear();
        bus.sym_in_i = 5'd26;
        bus.ready_i  = 1'b1;
        tick();
        chk("bad sym err", bus.err_o, 1);
        chk("bad sym count", bus.count_o, 0);
        bus.ready_i  = 1'b0;
        tick();
        chk("bad sym err drop", bus.err_o, 0);
        capture(1);
        capture(2);
        capture(3);
        capture(4);
        bus.sym_in_i = 5'd5;
        bus.ready_i  = 1'b1;
        tick();
        chk("full err", bus.err_o, 1);
        chk("full count", bus.count_o, 4);
        bus.ready_i  = 1'b0;
        tick();
        chk("full saida", bus.saida_o, pk(1, 2, 3, 4));

        do_clear();
        bus.sym_in_i = 5'd5;
        bus.ready_i  = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.ready_i  = 1'b0;
        tick();
        chk("held ready count", bus.count_o, 1);
        chk("held ready err", bus.err_o, 0);
        cipher("k26 identity", 26, 1'b0, 1);
        chk("k26 saida", bus.saida_o, pk(5, 31, 31, 31));

        do_clear();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("empty start ignored", bus.busy_o, 0);
        tick();

        capture(1);
        capture(2);
        capture(3);
        bus.shift_key_i = 5'd1;
        bus.decrypt_i   = 1'b0;
        bus.start_i     = 1'b1;
        tick();
        bus.start_i     = 1'b0;
        tick();
        bus.clear_i     = 1'b1;
        tick();
        bus.clear_i     = 1'b0;
        chk("abort busy", bus.busy_o, 0);
        chk("abort count", bus.count_o, 0);
        chk("abort saida", bus.saida_o, 20'hFFFFF);
        done_seen = bus.done_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            done_seen |= bus.done_o;
        end
        chk("abort no done", done_seen, 0);

        capture(6);
        capture(8);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset abort busy", bus.busy_o, 0);
        chk("reset abort count", bus.count_o, 0);
        chk("reset abort saida", bus.saida_o, 20'hFFFFF);
        done_seen = bus.done_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            done_seen |= bus.done_o;
        end
        chk("reset abort no done", done_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
